// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Receive-side checker for a serial LFSR (PRBS) bit stream.
//            Seeds a local predictor from the incoming bits, locks once
//            enough consecutive predictions match, then flags mismatches and
//            keeps a saturating error count. While locked the predictor
//            free-runs (flywheel), so one line error is counted only once.
//
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            in_valid   - in_bit is sampled this cycle
//            in_bit     - serial LFSR bit under test
//            clr_cnt    - synchronous clear of err_count (wins over increment)
//            locked     - high while the checker is in lock
//            err        - one-cycle registered pulse per mismatch while locked
//            err_count  - saturating count of mismatches while locked
//
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS        = 4'b1100,
    parameter int               LOCK_COUNT  = 8,
    parameter int               LOSS_THRESH = 3,
    parameter int               ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    localparam int              c_FILL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_FILL_W-1:0] c_FILL_LAST  = c_FILL_W'(WIDTH - 1);
    localparam logic [7:0]      c_MATCH_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [3:0]      c_LOSS_LAST  = 4'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_s;
    logic [WIDTH-1:0]    w_s_nxt;
    logic [c_FILL_W-1:0] r_fill;
    logic [c_FILL_W-1:0] w_fill_nxt;
    logic [7:0]          r_match;
    logic [7:0]          w_match_nxt;
    logic [3:0]          r_bad;
    logic [3:0]          w_bad_nxt;
    logic                r_err;
    logic                w_err_nxt;
    logic [ERR_W-1:0]    r_cnt;
    logic [ERR_W-1:0]    w_cnt_nxt;
    logic                w_cnt_inc;
    logic                w_pred;
    logic                w_hit;

    // Predicted next bit from the current history (s[0] is the newest bit).
    assign w_pred = ^(r_s & TAPS);
    assign w_hit  = (in_bit == w_pred);

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_fill_nxt  = r_fill;
        w_match_nxt = r_match;
        w_bad_nxt   = r_bad;
        w_err_nxt   = 1'b0;
        w_cnt_inc   = 1'b0;

        if (in_valid) begin
            case (r_state)
                ST_FILL: begin
                    w_s_nxt = {r_s[WIDTH-2:0], in_bit};
                    if (r_fill == c_FILL_LAST) begin
                        w_state_nxt = ST_SYNC;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end

                ST_SYNC: begin
                    // Self-synchronising: history always follows the line.
                    w_s_nxt = {r_s[WIDTH-2:0], in_bit};
                    // An all-zero history predicts 0 forever; refusing to
                    // count it keeps a stuck-at-0 line from ever locking.
                    if (w_hit && (r_s != '0)) begin
                        if (r_match == c_MATCH_LAST) begin
                            w_state_nxt = ST_LOCKED;
                            w_match_nxt = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_match_nxt = r_match + 1'b1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end

                ST_LOCKED: begin
                    // Flywheel: feed back our own prediction so a corrupted
                    // line bit cannot poison later predictions.
                    w_s_nxt = {r_s[WIDTH-2:0], w_pred};
                    if (w_hit) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (r_bad == c_LOSS_LAST) begin
                            w_state_nxt = ST_FILL;
                            w_fill_nxt  = '0;
                            w_bad_nxt   = '0;
                        end else begin
                            w_bad_nxt = r_bad + 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_nxt = ST_FILL;
                    w_fill_nxt  = '0;
                end
            endcase
        end

        if (clr_cnt) begin
            w_cnt_nxt = '0;
        end else if (w_cnt_inc && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_s     <= '0;
            r_fill  <= '0;
            r_match <= '0;
            r_bad   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_fill  <= w_fill_nxt;
            r_match <= w_match_nxt;
            r_bad   <= w_bad_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign locked    = (r_state == ST_LOCKED);
    assign err       = r_err;
    assign err_count = r_cnt;

endmodule
`default_nettype wire
